// File: rtl/permutation_core_pkg.sv
// Shared types and constants for the iterative Ascon permutation.
//   type_state  : five 64-bit words, word 0 = x0 ... word 4 = x4
//   type_idx    : 4-bit round index (0..11)
//   ROUND_CONST : constant XORed into x2[7:0] for round index 0..11
//   ROUNDS_*    : the legal round counts for p^b (6, 8) and p^a (12)
package permutation_core_pkg;

    typedef logic [4:0][63:0] type_state;
    typedef logic [3:0]       type_idx;

    localparam logic [3:0] ROUNDS_6  = 4'd6;
    localparam logic [3:0] ROUNDS_8  = 4'd8;
    localparam logic [3:0] ROUNDS_12 = 4'd12;

    localparam logic [7:0] ROUND_CONST [0:11] = '{
        8'hF0, 8'hE1, 8'hD2, 8'hC3, 8'hB4, 8'hA5,
        8'h96, 8'h87, 8'h78, 8'h69, 8'h5A, 8'h4B
    };

endpackage

// File: rtl/permutation_core_diffusion.sv
// Ascon linear diffusion layer p_L: each word XORed with two right
// rotations of itself (x0: 19/28, x1: 61/39, x2: 1/6, x3: 10/17, x4: 7/41).
//   state_i : substituted state
//   state_o : round output
// Purely combinational.
module permutation_core_diffusion
    import permutation_core_pkg::*;
(
    input  type_state state_i,
    output type_state state_o
);

    logic [63:0] x0, x1, x2, x3, x4;

    assign x0 = state_i[0];
    assign x1 = state_i[1];
    assign x2 = state_i[2];
    assign x3 = state_i[3];
    assign x4 = state_i[4];

    assign state_o[0] = x0 ^ {x0[18:0], x0[63:19]} ^ {x0[27:0], x0[63:28]};
    assign state_o[1] = x1 ^ {x1[60:0], x1[63:61]} ^ {x1[38:0], x1[63:39]};
    assign state_o[2] = x2 ^ {x2[0],    x2[63:1]}  ^ {x2[5:0],  x2[63:6]};
    assign state_o[3] = x3 ^ {x3[9:0],  x3[63:10]} ^ {x3[16:0], x3[63:17]};
    assign state_o[4] = x4 ^ {x4[6:0],  x4[63:7]}  ^ {x4[40:0], x4[63:41]};

endmodule

// File: rtl/permutation_core_substitution.sv
// Ascon substitution layer p_S: the 5-bit S-box applied to all 64 bit
// columns at once, in bit-sliced form. Bit j of word 0 is the S-box MSB.
//   state_i : state after constant addition
//   state_o : substituted state
// Purely combinational.
module permutation_core_substitution
    import permutation_core_pkg::*;
(
    input  type_state state_i,
    output type_state state_o
);

    logic [63:0] x0, x1, x2, x3, x4;
    logic [63:0] t0, t1, t2, t3, t4;

    always_comb begin
        x0 = state_i[0] ^ state_i[4];
        x1 = state_i[1];
        x2 = state_i[2] ^ state_i[1];
        x3 = state_i[3];
        x4 = state_i[4] ^ state_i[3];

        t0 = ~x0 & x1;
        t1 = ~x1 & x2;
        t2 = ~x2 & x3;
        t3 = ~x3 & x4;
        t4 = ~x4 & x0;

        x0 = x0 ^ t1;
        x1 = x1 ^ t2;
        x2 = x2 ^ t3;
        x3 = x3 ^ t4;
        x4 = x4 ^ t0;

        x1 = x1 ^ x0;
        x0 = x0 ^ x4;
        x3 = x3 ^ x2;
        x2 = ~x2;

        state_o = {x4, x3, x2, x1, x0};
    end

endmodule

// File: rtl/permutation_core.sv
// Iterative Ascon permutation: one full round (p_C, p_S, p_L) per clock
// for 6, 8 or 12 rounds, with a start/busy/done handshake.
//   clock_i  : clock, rising edge
//   resetb_i : asynchronous active-low reset
//   start_i  : request a permutation (taken only when idle)
//   rounds_i : 6, 8 or 12; any other value drops the request
//   state_i  : state loaded on an accepted start
//   state_o  : state register
//   busy_o   : rounds in progress
//   done_o   : one-cycle pulse after the final round
//
// state    | meaning
// ---------+-----------------------------------------------------------
// FSM_IDLE | waiting for start; state register holds the last result
// FSM_RUN  | applying one round per clock, idx counts up to 11
module permutation_core
    import permutation_core_pkg::*;
(
    input  logic      clock_i,
    input  logic      resetb_i,
    input  logic      start_i,
    input  logic [3:0] rounds_i,
    input  type_state state_i,
    output type_state state_o,
    output logic      busy_o,
    output logic      done_o
);

    localparam logic [0:0] FSM_IDLE = 1'b0;
    localparam logic [0:0] FSM_RUN  = 1'b1;

    logic [0:0] fsm_q, fsm_d;
    type_idx    idx_q, idx_d;
    type_state  state_q, state_d;
    logic       done_q, done_d;

    type_state  state_c;
    type_state  state_s;
    type_state  state_l;
    logic       rounds_ok;

    assign rounds_ok = (rounds_i == ROUNDS_6) || (rounds_i == ROUNDS_8) ||
                       (rounds_i == ROUNDS_12);

    always_comb begin
        state_c          = state_q;
        state_c[2][7:0]  = state_q[2][7:0] ^ ROUND_CONST[idx_q];
    end

    permutation_core_substitution u_substitution (
        .state_i (state_c),
        .state_o (state_s)
    );

    permutation_core_diffusion u_diffusion (
        .state_i (state_s),
        .state_o (state_l)
    );

    always_comb begin
        fsm_d   = fsm_q;
        idx_d   = idx_q;
        state_d = state_q;
        done_d  = 1'b0;
        if (fsm_q == FSM_IDLE) begin
            if (start_i && rounds_ok) begin
                state_d = state_i;
                // Shorter permutations run the tail of the 12-round schedule.
                idx_d   = ROUNDS_12 - rounds_i;
                fsm_d   = FSM_RUN;
            end
        end else begin
            state_d = state_l;
            if (idx_q == 4'd11) begin
                fsm_d  = FSM_IDLE;
                done_d = 1'b1;
            end else begin
                idx_d = idx_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            fsm_q   <= FSM_IDLE;
            idx_q   <= '0;
            state_q <= '0;
            done_q  <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            idx_q   <= idx_d;
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    assign state_o = state_q;
    assign busy_o  = (fsm_q == FSM_RUN);
    assign done_o  = done_q;

endmodule

// File: tb/tb_permutation_core.sv
module tb_permutation_core;
    import permutation_core_pkg::*;

    logic       clk;
    logic       resetb;
    logic       start;
    logic [3:0] rounds;
    type_state  st_in;
    type_state  st_out;
    logic       busy;
    logic       done;

    int n_vec = 0;
    int n_err = 0;
    int done_cnt = 0;
    type_state sb [$];

    localparam logic [4:0] SBOX [0:31] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
    };

    permutation_core dut (
        .clock_i  (clk),
        .resetb_i (resetb),
        .start_i  (start),
        .rounds_i (rounds),
        .state_i  (st_in),
        .state_o  (st_out),
        .busy_o   (busy),
        .done_o   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    function automatic logic [63:0] rotr(input logic [63:0] x, input int a);
        return (x >> a) | (x << (64 - a));
    endfunction

    function automatic type_state model(input type_state s, input int n);
        type_state t;
        logic [4:0] v, o;
        logic [7:0] c;
        for (int r = 12 - n; r < 12; r++) begin
            c = 8'(((15 - r) << 4) | r);
            t = s;
            t[2][7:0] = t[2][7:0] ^ c;
            for (int j = 0; j < 64; j++) begin
                v = {t[0][j], t[1][j], t[2][j], t[3][j], t[4][j]};
                o = SBOX[v];
                s[0][j] = o[4]; s[1][j] = o[3]; s[2][j] = o[2];
                s[3][j] = o[1]; s[4][j] = o[0];
            end
            s[0] = s[0] ^ rotr(s[0], 19) ^ rotr(s[0], 28);
            s[1] = s[1] ^ rotr(s[1], 61) ^ rotr(s[1], 39);
            s[2] = s[2] ^ rotr(s[2], 1)  ^ rotr(s[2], 6);
            s[3] = s[3] ^ rotr(s[3], 10) ^ rotr(s[3], 17);
            s[4] = s[4] ^ rotr(s[4], 7)  ^ rotr(s[4], 41);
        end
        return s;
    endfunction

    function automatic type_state rand_state();
        type_state s;
        for (int w = 0; w < 5; w++) s[w] = {$urandom(), $urandom()};
        return s;
    endfunction

    // Called at a negedge: drive a start, push the expected result, step past
    // the accepting edge and return at the following negedge.
    task automatic kick(input type_state s, input logic [3:0] n, input bit hold);
        start  = 1'b1;
        rounds = n;
        st_in  = s;
        sb.push_back(model(s, int'(n)));
        @(posedge clk);
        @(negedge clk);
        if (!hold) start = 1'b0;
        st_in = rand_state();
    endtask

    task automatic wait_done(output int edges, output type_state st, output bit ok);
        ok = 1'b0; edges = 0; st = '0;
        while (!ok && edges < 30) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (done === 1'b1) begin
                ok = 1'b1;
                st = st_out;
            end
        end
    endtask

    task automatic test_reset();
        resetb = 1'b0; start = 1'b0; rounds = 4'd0; st_in = '0;
        #1;
        n_vec++; if (st_out !== '0) begin n_err++; $display("FAIL reset_state: got %h expected 0", st_out); end
        n_vec++; if ({busy, done} !== 2'b00) begin n_err++; $display("FAIL reset_flags: got busy=%b done=%b expected 0 0", busy, done); end
        repeat (2) @(negedge clk);
        resetb = 1'b1;
        @(negedge clk);
        n_vec++; if ({busy, done} !== 2'b00) begin n_err++; $display("FAIL post_reset_flags: got busy=%b done=%b expected 0 0", busy, done); end
    endtask

    task automatic test_pa();
        type_state s, st, exp;
        int e; bit ok;
        s[0] = 64'h80400c0600000000;
        s[1] = 64'h0001020304050607;
        s[2] = 64'h08090a0b0c0d0e0f;
        s[3] = 64'h1011121314151617;
        s[4] = 64'h18191a1b1c1d1e1f;
        kick(s, 4'd12, 1'b0);
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL pa_busy: got %b expected 1", busy); end
        wait_done(e, st, ok);
        exp = sb.pop_front();
        n_vec++; if (!ok || e != 12) begin n_err++; $display("FAIL pa_latency: got %0d edges (seen=%0b) expected 12", e, ok); end
        n_vec++; if (st !== exp) begin n_err++; $display("FAIL pa_state: got %h expected %h", st, exp); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL pa_busy_at_done: got %b expected 0", busy); end
        @(negedge clk);
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL pa_done_pulse: got %b expected 0", done); end
        n_vec++; if (st_out !== exp) begin n_err++; $display("FAIL pa_state_hold: got %h expected %h", st_out, exp); end
    endtask

    task automatic test_pb();
        logic [3:0] tbl [2];
        type_state st, exp;
        int e; bit ok;
        tbl[0] = 4'd6; tbl[1] = 4'd8;
        for (int i = 0; i < 2; i++) begin
            kick(rand_state(), tbl[i], 1'b0);
            wait_done(e, st, ok);
            exp = sb.pop_front();
            n_vec++; if (!ok || e != int'(tbl[i])) begin n_err++; $display("FAIL pb%0d_latency: got %0d edges expected %0d", tbl[i], e, tbl[i]); end
            n_vec++; if (st !== exp) begin n_err++; $display("FAIL pb%0d_state: got %h expected %h", tbl[i], st, exp); end
            @(negedge clk);
        end
    endtask

    task automatic test_ignored();
        type_state st, exp, prev;
        int e, d0; bit ok;
        logic [3:0] bad [3];
        d0 = done_cnt;
        kick(rand_state(), 4'd8, 1'b1);
        rounds = 4'd12;
        wait_done(e, st, ok);
        start = 1'b0;
        exp = sb.pop_front();
        n_vec++; if (!ok || e != 8) begin n_err++; $display("FAIL held_latency: got %0d edges expected 8", e); end
        n_vec++; if (st !== exp) begin n_err++; $display("FAIL held_state: got %h expected %h", st, exp); end
        repeat (4) @(negedge clk);
        n_vec++; if (done_cnt - d0 != 1) begin n_err++; $display("FAIL held_done_count: got %0d expected 1", done_cnt - d0); end
        bad[0] = 4'd5; bad[1] = 4'd0; bad[2] = 4'd15;
        for (int i = 0; i < 3; i++) begin
            prev = st_out;
            start = 1'b1; rounds = bad[i]; st_in = rand_state();
            @(posedge clk); @(negedge clk);
            start = 1'b0;
            n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL bad%0d_busy: got %b expected 0", bad[i], busy); end
            n_vec++; if (st_out !== prev) begin n_err++; $display("FAIL bad%0d_state: got %h expected %h", bad[i], st_out, prev); end
        end
    endtask

    task automatic test_back_to_back();
        type_state st, exp;
        int e; bit ok;
        kick(rand_state(), 4'd6, 1'b0);
        wait_done(e, st, ok);
        exp = sb.pop_front();
        n_vec++; if (!ok || st !== exp) begin n_err++; $display("FAIL b2b_first: got %h expected %h", st, exp); end
        kick(rand_state(), 4'd8, 1'b0);
        n_vec++; if ({busy, done} !== 2'b10) begin n_err++; $display("FAIL b2b_no_gap: got busy=%b done=%b expected 1 0", busy, done); end
        wait_done(e, st, ok);
        exp = sb.pop_front();
        n_vec++; if (!ok || e != 8) begin n_err++; $display("FAIL b2b_latency: got %0d edges expected 8", e); end
        n_vec++; if (st !== exp) begin n_err++; $display("FAIL b2b_second: got %h expected %h", st, exp); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        type_state st, exp;
        int e, d0; bit ok;
        d0 = done_cnt;
        kick(rand_state(), 4'd12, 1'b0);
        repeat (3) @(posedge clk);
        #2 resetb = 1'b0;
        void'(sb.pop_front());
        #1;
        n_vec++; if (st_out !== '0) begin n_err++; $display("FAIL midrst_state: got %h expected 0", st_out); end
        n_vec++; if ({busy, done} !== 2'b00) begin n_err++; $display("FAIL midrst_flags: got busy=%b done=%b expected 0 0", busy, done); end
        @(negedge clk);
        resetb = 1'b1;
        repeat (14) @(negedge clk);
        n_vec++; if (done_cnt != d0) begin n_err++; $display("FAIL midrst_stray_done: got %0d pulses expected 0", done_cnt - d0); end
        kick(rand_state(), 4'd12, 1'b0);
        wait_done(e, st, ok);
        exp = sb.pop_front();
        n_vec++; if (!ok || e != 12) begin n_err++; $display("FAIL midrst_latency: got %0d edges expected 12", e); end
        n_vec++; if (st !== exp) begin n_err++; $display("FAIL midrst_state_after: got %h expected %h", st, exp); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_pa();
        test_pb();
        test_ignored();
        test_back_to_back();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
